lbdr_input_fifo: RTL
====================

Name: lbdr_input_fifo

Overview:
- Per-input-port flit buffer that sits directly upstream of the LBDR routing stage.
- Stores incoming flits and presents the head flit in show-ahead form, so the routing stage sees valid head data in the same cycle that the FIFO reports non-empty. Head data is presented as: empty, flit_id[2:0], dst_addr[3:0].
- A write-side framing FSM enforces the HEADER..PAYLOAD..TAIL packet order and drops malformed flits.

Parameters:
- DEPTH, 4, number of flit entries; must be a power of 2, at least 2.
- PTR_W, 2, log2(DEPTH).
- DATA_WIDTH, 32, flit width in bits; must be at least 8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid_in  input  1  upstream presents a flit on data_in this cycle.
- data_in  input  DATA_WIDTH  incoming flit. [DATA_WIDTH-1:DATA_WIDTH-3] is the flit id; on a HEADER flit, [3:0] is dst_addr and [7:4] is src_addr.
- ready_out  output  1  equals ~full; upstream may write only when this is high.
- read_en  input  1  downstream pops the head flit.
- empty  output  1  FIFO holds no flits.
- full  output  1  FIFO holds DEPTH flits.
- data_out  output  DATA_WIDTH  head flit (show-ahead); 0 when empty.
- flit_id  output  3  data_out[DATA_WIDTH-1:DATA_WIDTH-3].
- dst_addr  output  4  data_out[3:0].
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- frame_err  output  1  sticky framing-error flag.
- drop_cnt  output  8  number of dropped flits; saturates at 255.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers and count go to 0; empty=1, full=0, frame_err=0, drop_cnt=0.
  - Framing FSM goes to IDLE. Storage contents need not be cleared.
  - Reset asserted mid-packet discards all buffered flits; there is no partial-packet recovery.
- Write (push):
  - A write occurs on a rising edge when valid_in=1, full=0 and the framing FSM accepts the flit.
  - valid_in while full is ignored; upstream must hold the flit. There is no write-through when full, even if read_en=1.
- Read (pop):
  - A read occurs on a rising edge when read_en=1 and empty=0. read_en while empty is a no-op.
- Simultaneous write and read with 0<count<DEPTH: both pointers advance and count is unchanged.
  - With count=0, only the write occurs; the flit is not visible until the next cycle.
- Latency: a flit written at edge N is visible on data_out/flit_id/dst_addr, with empty=0, from just after edge N.
  - These outputs are combinational from rd_ptr, with no extra register stage.
- Pointers: wr_ptr and rd_ptr are PTR_W bits and wrap modulo DEPTH.
  - full and empty derive from count (count==DEPTH, count==0).
- Framing FSM (write side only), states IDLE and IN_PKT, using the codebase HEADER/PAYLOAD/TAIL encodings:
  - IDLE + HEADER: accept, go to IN_PKT.
  - IDLE + PAYLOAD or TAIL: drop (no write), set frame_err, increment drop_cnt, stay in IDLE.
  - IN_PKT + PAYLOAD: accept, stay in IN_PKT.
  - IN_PKT + TAIL: accept, go to IDLE.
  - IN_PKT + HEADER: accept (a new packet starts), set frame_err, stay in IN_PKT.
  - Unknown flit_id in either state: drop, set frame_err, increment drop_cnt, state unchanged.
  - FSM transitions are taken only for flits that pass the full check. A flit held back by full causes no FSM change.
- frame_err clears only on reset. drop_cnt saturates at 255.
- data_out is forced to 0 when empty, so flit_id reads 0 and downstream never decodes stale data.

Test Plan:
- Reset, then write HEADER (dst_addr=4'hA), PAYLOAD, TAIL on consecutive cycles with read_en=0 -> one cycle after the first edge: empty=0, flit_id=HEADER, dst_addr=4'hA; count reaches 3.
- With DEPTH=4, write 5 valid flits back to back with no reads -> full=1 and ready_out=0 after the 4th; the 5th is not stored; count=4. Pop 4 -> the flits return in order, then empty=1 and data_out=0.
- Hold count=2, assert valid_in and read_en together for 10 cycles with pointers crossing the wrap -> count stays 2; the output order matches the input order.
- From IDLE, write PAYLOAD -> not stored, frame_err=1, drop_cnt=1, empty stays 1. A following HEADER is accepted.
- In IN_PKT, write HEADER -> stored, frame_err=1, drop_cnt unchanged; a TAIL then returns the FSM to IDLE.
- With 3 flits buffered mid-packet, pulse rst low asynchronously between edges -> empty=1, count=0, frame_err=0 immediately. After release, a PAYLOAD is dropped (FSM is in IDLE).

Source files
------------

// File: rtl/lbdr_input_fifo.sv
// rtl/lbdr_input_fifo.sv - show-ahead input flit FIFO with write-side packet framing check
module lbdr_input_fifo #(
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  input  logic                  read_en,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic [PTR_W:0]        count,
  output logic                  frame_err,
  output logic [7:0]            drop_cnt
);

  localparam logic [2:0] FLIT_HEADER  = 3'b001;
  localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0] FLIT_TAIL    = 3'b100;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {IDLE, IN_PKT} frame_state_t;

  frame_state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [2:0]            in_id;
  logic                  attempt, accept, drop, set_err;
  logic                  do_write, do_read;

  assign in_id     = data_in[DATA_WIDTH-1:DATA_WIDTH-3];
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign ready_out = ~full;

  // A flit held back by full is invisible to the framing check.
  assign attempt  = valid_in & ~full;
  assign do_write = accept;
  assign do_read  = read_en & ~empty;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    drop       = 1'b0;
    set_err    = 1'b0;
    if (attempt) begin
      case (in_id)
        FLIT_HEADER: begin
          accept     = 1'b1;
          set_err    = (state == IN_PKT);
          state_next = IN_PKT;
        end
        FLIT_PAYLOAD: begin
          if (state == IN_PKT) begin
            accept = 1'b1;
          end else begin
            drop    = 1'b1;
            set_err = 1'b1;
          end
        end
        FLIT_TAIL: begin
          if (state == IN_PKT) begin
            accept     = 1'b1;
            state_next = IDLE;
          end else begin
            drop    = 1'b1;
            set_err = 1'b1;
          end
        end
        default: begin
          drop    = 1'b1;
          set_err = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state <= state_next;
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (set_err) frame_err <= 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Storage is not reset; empty gating below hides stale entries.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= data_in;
  end

  assign data_out = empty ? '0 : mem[rd_ptr];
  assign flit_id  = data_out[DATA_WIDTH-1:DATA_WIDTH-3];
  assign dst_addr = data_out[3:0];

endmodule
